// File: rtl/buzzer_arbiter.sv
// Fixed-priority preemptive buzzer arbiter (done > warn > key) with tone/pattern sequencer.
// Define BUZZER_MUTE_EN to add the mute input that suppresses key beeps.
module buzzer_arbiter #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned KEY_HZ     = 1000,
  parameter int unsigned DONE_HZ    = 800,
  parameter int unsigned WARN_HZ    = 2000,
  parameter int unsigned KEY_MS     = 100,
  parameter int unsigned DONE_ON_MS = 500,
  parameter int unsigned DONE_REPS  = 3,
  parameter int unsigned WARN_MS    = 100,
  parameter int unsigned WARN_REPS  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_key,
  input  logic       req_done,
  input  logic       req_warn,
`ifdef BUZZER_MUTE_EN
  input  logic       mute,
`endif
  output logic       buzzer,
  output logic [2:0] grant,
  output logic       busy,
  output logic       pattern_done
);

  localparam int unsigned CycPerMs = CLK_HZ / 1000;
  localparam int unsigned KeyLen   = KEY_MS * CycPerMs;
  localparam int unsigned DoneLen  = DONE_ON_MS * CycPerMs;
  localparam int unsigned WarnLen  = WARN_MS * CycPerMs;
  localparam int unsigned MaxLen01 = (KeyLen > DoneLen) ? KeyLen : DoneLen;
  localparam int unsigned MaxLen   = (MaxLen01 > WarnLen) ? MaxLen01 : WarnLen;

  localparam int unsigned KeyHalf  = CLK_HZ / (2 * KEY_HZ);
  localparam int unsigned DoneHalf = CLK_HZ / (2 * DONE_HZ);
  localparam int unsigned WarnHalf = CLK_HZ / (2 * WARN_HZ);
  localparam int unsigned MaxHf01  = (KeyHalf > DoneHalf) ? KeyHalf : DoneHalf;
  localparam int unsigned MaxHalf  = (MaxHf01 > WarnHalf) ? MaxHf01 : WarnHalf;

  localparam int unsigned MaxRp01  = (DONE_REPS > WARN_REPS) ? DONE_REPS : WARN_REPS;
  localparam int unsigned MaxReps  = (MaxRp01 > 1) ? MaxRp01 : 1;

  localparam int MsW   = $clog2(MaxLen) + 1;
  localparam int ToneW = $clog2(MaxHalf) + 1;
  localparam int RepW  = $clog2(MaxReps) + 1;

  localparam logic [2:0] SrcKey  = 3'b001;
  localparam logic [2:0] SrcWarn = 3'b010;
  localparam logic [2:0] SrcDone = 3'b100;

  typedef enum logic [1:0] {StIdle, StToneOn, StToneOff} state_e;

  state_e             state;
  logic [MsW-1:0]     ms_cnt;
  logic [ToneW-1:0]   tone_cnt;
  logic [RepW-1:0]    rep_cnt;

  logic [MsW-1:0]     phase_last;
  logic [ToneW-1:0]   half_last;
  logic [RepW-1:0]    rep_last;
  logic [2:0]         new_src;
  logic               key_ok;
  logic               mute_kill;
  logic               phase_end;
  logic               finishing;
  logic               accept;

`ifdef BUZZER_MUTE_EN
  assign key_ok    = req_key & ~mute;
  assign mute_kill = mute && (grant == SrcKey);
`else
  assign key_ok    = req_key;
  assign mute_kill = 1'b0;
`endif

  // Phase length, half period and burst count of the source currently granted.
  always_comb begin
    phase_last = MsW'(KeyLen - 1);
    half_last  = ToneW'(KeyHalf - 1);
    rep_last   = '0;
    unique case (grant)
      SrcDone: begin
        phase_last = MsW'(DoneLen - 1);
        half_last  = ToneW'(DoneHalf - 1);
        rep_last   = RepW'(DONE_REPS - 1);
      end
      SrcWarn: begin
        phase_last = MsW'(WarnLen - 1);
        half_last  = ToneW'(WarnHalf - 1);
        rep_last   = RepW'(WARN_REPS - 1);
      end
      default: ;
    endcase
  end

  always_comb begin
    new_src = 3'b000;
    if (req_done)      new_src = SrcDone;
    else if (req_warn) new_src = SrcWarn;
    else if (key_ok)   new_src = SrcKey;
  end

  assign phase_end = (ms_cnt == phase_last);
  assign finishing = (state == StToneOn) && phase_end && (rep_cnt == rep_last);
  // One-hot ordering makes numeric compare equal to priority compare; idle grant is 0.
  assign accept    = (new_src > grant) || (finishing && (new_src != 3'b000));

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= StIdle;
      grant        <= 3'b000;
      busy         <= 1'b0;
      buzzer       <= 1'b0;
      pattern_done <= 1'b0;
      ms_cnt       <= '0;
      tone_cnt     <= '0;
      rep_cnt      <= '0;
    end else begin
      pattern_done <= 1'b0;
      if (accept) begin
        state        <= StToneOn;
        grant        <= new_src;
        busy         <= 1'b1;
        buzzer       <= 1'b0;
        pattern_done <= finishing;
        ms_cnt       <= '0;
        tone_cnt     <= '0;
        rep_cnt      <= '0;
      end else if (mute_kill) begin
        state    <= StIdle;
        grant    <= 3'b000;
        busy     <= 1'b0;
        buzzer   <= 1'b0;
        ms_cnt   <= '0;
        tone_cnt <= '0;
        rep_cnt  <= '0;
      end else begin
        unique case (state)
          StIdle: ;
          StToneOn: begin
            if (phase_end) begin
              ms_cnt   <= '0;
              tone_cnt <= '0;
              buzzer   <= 1'b0;
              if (rep_cnt == rep_last) begin
                state        <= StIdle;
                grant        <= 3'b000;
                busy         <= 1'b0;
                pattern_done <= 1'b1;
                rep_cnt      <= '0;
              end else begin
                state   <= StToneOff;
                rep_cnt <= rep_cnt + 1'b1;
              end
            end else begin
              ms_cnt <= ms_cnt + 1'b1;
              if (tone_cnt == half_last) begin
                tone_cnt <= '0;
                buzzer   <= ~buzzer;
              end else begin
                tone_cnt <= tone_cnt + 1'b1;
              end
            end
          end
          StToneOff: begin
            if (phase_end) begin
              state    <= StToneOn;
              ms_cnt   <= '0;
              tone_cnt <= '0;
              buzzer   <= 1'b0;
            end else begin
              ms_cnt <= ms_cnt + 1'b1;
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule
